// File: rtl/divergence_stack_if.sv
// Command/status bundle for divergence_stack: the master issues push/pop/comp,
// the slave returns the active mask, stack status and sticky error flags.
interface divergence_stack_if #(
    parameter int N_LANES = 4,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 8
);
    logic                       push;
    logic                       pop;
    logic                       comp;
    logic [N_LANES-1:0]         d_mask;
    logic [PC_W-1:0]            d_pc;
    logic                       err_clr;
    logic [N_LANES-1:0]         q_mask;
    logic [PC_W-1:0]            q_pc;
    logic                       all_true;
    logic                       all_false;
    logic                       empty;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] level;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, pop, comp, d_mask, d_pc, err_clr,
        input  q_mask, q_pc, all_true, all_false, empty, full, level,
               overflow, underflow
    );

    modport slave (
        input  push, pop, comp, d_mask, d_pc, err_clr,
        output q_mask, q_pc, all_true, all_false, empty, full, level,
               overflow, underflow
    );
endinterface

// File: rtl/divergence_stack.sv
// SIMT divergence stack: active lane mask plus a stack of {mask, reconvergence PC}.
// Define DSTACK_ERR_EN to enable the sticky overflow/underflow flags and err_clr.
module divergence_stack #(
    parameter int N_LANES = 4,
    parameter int DEPTH   = 8,
    parameter int PC_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    divergence_stack_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N_LANES-1:0] act_mask;
    logic [LVL_W-1:0]   lvl;
    logic [N_LANES-1:0] mask_mem [DEPTH];
    logic [PC_W-1:0]    pc_mem   [DEPTH];

    logic [IDX_W-1:0]   top_idx;
    logic [IDX_W-1:0]   push_idx;
    logic [N_LANES-1:0] top_mask;
    logic               is_empty;
    logic               is_full;
    logic               do_push;
    logic               do_pop;
    logic               do_comp;

    assign is_empty = (lvl == '0);
    assign is_full  = (lvl == LVL_W'(DEPTH));
    assign top_idx  = IDX_W'(lvl - LVL_W'(1));
    assign push_idx = IDX_W'(lvl);
    assign top_mask = mask_mem[top_idx];

    // Priority pop > push > comp; a losing command is dropped even if the winner is illegal.
    assign do_pop  = bus.pop && !is_empty;
    assign do_push = bus.push && !bus.pop && !is_full;
    assign do_comp = bus.comp && !bus.pop && !bus.push && !is_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_mask <= '1;
            lvl      <= '0;
        end else if (do_pop) begin
            act_mask <= top_mask;
            lvl      <= lvl - LVL_W'(1);
        end else if (do_push) begin
            act_mask <= act_mask & bus.d_mask;
            lvl      <= lvl + LVL_W'(1);
        end else if (do_comp) begin
            act_mask <= top_mask & ~act_mask;
        end
    end

    // Entry storage is never cleared; level alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mask_mem[push_idx] <= act_mask;
            pc_mem[push_idx]   <= bus.d_pc;
        end
    end

    assign bus.q_mask    = act_mask;
    assign bus.q_pc      = is_empty ? '0 : pc_mem[top_idx];
    assign bus.all_true  = &act_mask;
    assign bus.all_false = ~|act_mask;
    assign bus.empty     = is_empty;
    assign bus.full      = is_full;
    assign bus.level     = lvl;

`ifdef DSTACK_ERR_EN
    logic ovf_q;
    logic unf_q;
    logic ovf_evt;
    logic unf_evt;

    assign ovf_evt = bus.push && !bus.pop && is_full;
    assign unf_evt = (bus.pop || (bus.comp && !bus.push)) && is_empty;

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_evt | (ovf_q & ~bus.err_clr);
            unf_q <= unf_evt | (unf_q & ~bus.err_clr);
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
    assign bus.overflow   = 1'b0;
    assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_divergence_stack.sv
// Directed scoreboard bench for divergence_stack (N_LANES=4, DEPTH=4, PC_W=8).
module tb_divergence_stack;
`ifdef DSTACK_ERR_EN
    localparam logic EN = 1'b1;
`else
    localparam logic EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] mask;
        logic [7:0] pc;
        logic [2:0] lvl;
        logic       at;
        logic       af;
        logic       em;
        logic       fu;
        logic       ov;
        logic       un;
        int         due;
        int         id;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   n_issued = 0;
    exp_t sb[$];

    divergence_stack_if #(.N_LANES(4), .DEPTH(4), .PC_W(8)) bus ();

    divergence_stack #(.N_LANES(4), .DEPTH(4), .PC_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [3:0] mask, input logic [7:0] pc,
                                input logic [2:0] lvl, input logic ov, input logic un);
        exp_t e;
        e.mask = mask;
        e.pc   = pc;
        e.lvl  = lvl;
        e.at   = (mask == 4'b1111);
        e.af   = (mask == 4'b0000);
        e.em   = (lvl == 3'd0);
        e.fu   = (lvl == 3'd4);
        e.ov   = ov & EN;
        e.un   = un & EN;
        e.due  = 0;
        e.id   = 0;
        return e;
    endfunction

    task automatic step(input logic rs, input logic pu, input logic po, input logic co,
                        input logic ec, input logic [3:0] dm, input logic [7:0] dpc,
                        input exp_t e);
        reset       = rs;
        bus.push    = pu;
        bus.pop     = po;
        bus.comp    = co;
        bus.err_clr = ec;
        bus.d_mask  = dm;
        bus.d_pc    = dpc;
        n_issued    = n_issued + 1;
        e.due       = cyc + 1;
        e.id        = n_issued;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks = checks + 1;
            if ({bus.q_mask, bus.q_pc, bus.level, bus.all_true, bus.all_false, bus.empty,
                 bus.full, bus.overflow, bus.underflow} !==
                {e.mask, e.pc, e.lvl, e.at, e.af, e.em, e.fu, e.ov, e.un}) begin
                errors = errors + 1;
                $display("FAIL step%0d: got mask=%b pc=%h lvl=%0d at=%b af=%b em=%b fu=%b ov=%b un=%b, want mask=%b pc=%h lvl=%0d at=%b af=%b em=%b fu=%b ov=%b un=%b",
                         e.id, bus.q_mask, bus.q_pc, bus.level, bus.all_true, bus.all_false,
                         bus.empty, bus.full, bus.overflow, bus.underflow,
                         e.mask, e.pc, e.lvl, e.at, e.af, e.em, e.fu, e.ov, e.un);
            end
        end
    end

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.comp = 1'b0; bus.err_clr = 1'b0;
        bus.d_mask = 4'b0000; bus.d_pc = 8'h00;

        // reset overrides a push in the same cycle
        step(1, 1, 0, 0, 0, 4'b0101, 8'h99, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        // single divergence with comp toggling
        step(0, 1, 0, 0, 0, 4'b1010, 8'h10, mk(4'b1010, 8'h10, 3'd1, 0, 0));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b0101, 8'h10, 3'd1, 0, 0));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b1010, 8'h10, 3'd1, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        // nested divergence
        step(0, 1, 0, 0, 0, 4'b1100, 8'h20, mk(4'b1100, 8'h20, 3'd1, 0, 0));
        step(0, 1, 0, 0, 0, 4'b0110, 8'h30, mk(4'b0100, 8'h30, 3'd2, 0, 0));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b1000, 8'h30, 3'd2, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1100, 8'h20, 3'd1, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        // fill to full, then overflow and err_clr behaviour
        step(0, 1, 0, 0, 0, 4'b1111, 8'h41, mk(4'b1111, 8'h41, 3'd1, 0, 0));
        step(0, 1, 0, 0, 0, 4'b1111, 8'h42, mk(4'b1111, 8'h42, 3'd2, 0, 0));
        step(0, 1, 0, 0, 0, 4'b1111, 8'h43, mk(4'b1111, 8'h43, 3'd3, 0, 0));
        step(0, 1, 0, 0, 0, 4'b1111, 8'h44, mk(4'b1111, 8'h44, 3'd4, 0, 0));
        step(0, 1, 0, 0, 0, 4'b0000, 8'h55, mk(4'b1111, 8'h44, 3'd4, 1, 0));
        step(0, 0, 0, 0, 1, 4'b0000, 8'h00, mk(4'b1111, 8'h44, 3'd4, 0, 0));
        step(0, 1, 0, 0, 1, 4'b0000, 8'h56, mk(4'b1111, 8'h44, 3'd4, 1, 0));
        step(0, 0, 0, 0, 1, 4'b0000, 8'h00, mk(4'b1111, 8'h44, 3'd4, 0, 0));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b0000, 8'h44, 3'd4, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h43, 3'd3, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h42, 3'd2, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h41, 3'd1, 0, 0));
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        // underflow from pop and from comp
        step(0, 0, 1, 0, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        step(0, 0, 0, 0, 1, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        // priority and empty-mask push; underflow stays sticky
        step(0, 1, 0, 0, 0, 4'b1010, 8'h60, mk(4'b1010, 8'h60, 3'd1, 0, 1));
        step(0, 1, 1, 0, 0, 4'b1100, 8'h70, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        step(0, 1, 0, 1, 0, 4'b0110, 8'h71, mk(4'b0110, 8'h71, 3'd1, 0, 1));
        step(0, 1, 0, 0, 0, 4'b0000, 8'h72, mk(4'b0000, 8'h72, 3'd2, 0, 1));
        step(0, 0, 0, 1, 0, 4'b0000, 8'h00, mk(4'b0110, 8'h72, 3'd2, 0, 1));
        step(0, 1, 0, 0, 0, 4'b0011, 8'h73, mk(4'b0010, 8'h73, 3'd3, 0, 1));
        // reset mid-divergence with all commands asserted
        step(1, 1, 1, 1, 0, 4'b0001, 8'h74, mk(4'b1111, 8'h00, 3'd0, 0, 0));
        step(0, 1, 1, 0, 0, 4'b1010, 8'h75, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        step(0, 0, 1, 0, 1, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 1));
        step(0, 0, 0, 0, 1, 4'b0000, 8'h00, mk(4'b1111, 8'h00, 3'd0, 0, 0));

        reset = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.comp = 1'b0; bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divergence_stack.md
DIVERGENCE_STACK -- requirements
Module: divergence_stack

Interface
REQ-001 Parameter N_LANES, default 4, number of SIMT lanes (mask width).
REQ-002 Parameter DEPTH, default 8, number of stack entries, SHALL be >=2.
REQ-003 Parameter PC_W, default 8, width of stored reconvergence PC.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 push  in  1  save {active mask, d_pc}; narrow active mask by d_mask.
REQ-007 pop  in  1  restore active mask from top entry; discard top.
REQ-008 comp  in  1  switch active mask to else-path of current divergence.
REQ-009 d_mask  in  N_LANES  taken-branch lane predicate for push.
REQ-010 d_pc  in  PC_W  reconvergence PC stored with push.
REQ-011 err_clr  in  1  clears sticky overflow/underflow.
REQ-012 q_mask  out  N_LANES  current active mask.
REQ-013 q_pc  out  PC_W  PC of top entry; 0 when empty.
REQ-014 all_true  out  1  high when q_mask is all ones.
REQ-015 all_false  out  1  high when q_mask is all zeros.
REQ-016 empty  out  1  no entries stored.
REQ-017 full  out  1  DEPTH entries stored.
REQ-018 level  out  clog2(DEPTH+1)  number of stored entries.
REQ-019 overflow  out  1  sticky: push attempted while full.
REQ-020 underflow  out  1  sticky: pop or comp attempted while empty.

Function
REQ-021 Active mask register A and stack entries {mask, pc} SHALL be registered; all outputs reflect state after the triggering edge (1-cycle latency), all_true/all_false/empty/full/q_pc combinational from registers.
REQ-022 push, not full: entry[level] <= {A, d_pc}; A <= A & d_mask; level +1.
REQ-023 comp, not empty: A <= top.mask & ~A; level and entries unchanged; repeated comp toggles between paths.
REQ-024 pop, not empty: A <= top.mask; level -1.
REQ-025 Simultaneous commands: priority pop > push > comp; lower-priority commands in that cycle SHALL be ignored entirely.
REQ-026 push while full: no state change, overflow set.
REQ-027 pop or comp while empty: no state change, underflow set.
REQ-028 push with A & d_mask == 0 SHALL still be accepted (all_false asserted).
REQ-029 err_clr clears overflow/underflow; same-cycle new error SHALL win (flag stays set).
REQ-030 Stack SHALL not wrap; level saturates in [0, DEPTH].

Reset
REQ-031 On reset at clock edge: A = all ones, level = 0, empty = 1, full = 0, q_pc = 0, all_true = 1, all_false = 0, overflow = underflow = 0; entry contents need not be cleared.
REQ-032 reset SHALL override all commands in the same cycle, including mid-divergence (nonzero level).

Configuration
REQ-033 Macro DSTACK_ERR_EN: defined -> overflow/underflow/err_clr behave per REQ-026/027/029.
REQ-034 Undefined -> overflow and underflow tied 0, err_clr ignored; illegal commands still ignored with no state change.

Verification (N_LANES=4, DEPTH=4, PC_W=8, DSTACK_ERR_EN defined)
REQ-035 Reset, then push d_mask=1010 d_pc=0x10 -> q_mask=1010, q_pc=0x10, level=1; comp -> q_mask=0101; pop -> q_mask=1111, empty=1.
REQ-036 Nested: push 1100/0x20, push 0110/0x30 -> q_mask=0100, level=2; comp -> 1000; pop -> 1100, q_pc=0x20; pop -> 1111.
REQ-037 Push 4 times with d_mask=1111 -> full=1; 5th push -> overflow=1, level=4, q_mask unchanged; err_clr -> overflow=0.
REQ-038 From empty: pop -> underflow=1, q_mask=1111; comp -> state unchanged, level=0.
REQ-039 push+pop same cycle at level=1 -> pop only, level=0; push d_mask=0000 -> all_false=1, all_true=0.
REQ-040 Reset asserted at level=3 -> next cycle level=0, q_mask=1111, flags cleared; rerun REQ-035 with macro undefined -> overflow/underflow stay 0.
